// File: rtl/adc_pkg.sv
// Shared widths, state encoding and run configuration for the ADC capture path.
package adc_pkg;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned LEN_W    = 32;
  localparam int unsigned REC_W    = 16;
  localparam int unsigned HOLD_W   = 32;
  localparam int unsigned SAMPLE_W = 64;
  localparam int unsigned DROP_W   = 32;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_DONE    = 3'd5
  } cap_state_e;

  // Run parameters frozen when a run is armed
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [REC_W-1:0]  max_rec;
    logic [HOLD_W-1:0] holdoff;
  } run_cfg_t;

  // Zero-valued lengths/holdoffs behave as one
  function automatic logic [LEN_W-1:0] at_least_one(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

endpackage

// File: rtl/capture_out_reg.sv
// One-entry output holding register for the record stream, with saturating
// count of beats lost while the register is full and stalled.
module capture_out_reg
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  clr_drop,
  input  logic                  beat_valid,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic                  beat_last,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  accept_c,
  output logic [DROP_W-1:0]     dropped_count
);

  logic drop_c;

  // A full register frees up in the same cycle it is drained
  assign accept_c = beat_valid && (!m_axis_tvalid || m_axis_tready);
  assign drop_c   = beat_valid && m_axis_tvalid && !m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset || flush) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (accept_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= beat_last;
      m_axis_tdata  <= beat_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset || clr_drop) begin
      dropped_count <= '0;
    end else if (drop_c && (dropped_count != '1)) begin
      dropped_count <= DROP_W'(dropped_count + DROP_W'(1));
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition run controller: clears the ADC trigger path, waits for triggers,
// captures fixed-length records and spaces them with a holdoff.
module capture_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_W,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      record_len,
  input  logic [REC_W-1:0]      max_records,
  input  logic [HOLD_W-1:0]     holdoff_cycles,
  input  logic                  trig_in,
  input  logic [SAMPLE_W-1:0]   cur_sample,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  reset_trigger,
  output logic                  reset_max_sum,
  output logic [STATE_W-1:0]    state_o,
  output logic                  busy,
  output logic                  done,
  output logic [REC_W-1:0]      records_done,
  output logic [SAMPLE_W-1:0]   first_sample,
  output logic [DROP_W-1:0]     dropped_count
);

  localparam int unsigned CLR_LAST = (CLEAR_CYCLES == 0) ? 0 : CLEAR_CYCLES - 1;

  cap_state_e        state;
  cap_state_e        state_nx;
  run_cfg_t          cfg;
  logic [LEN_W-1:0]  beat_cnt;
  logic [HOLD_W-1:0] phase_cnt;

  logic              start_c;
  logic              trig_hit_c;
  logic              beat_valid_c;
  logic              beat_last_c;
  logic              accept_c;
  logic              rec_end_c;
  logic              run_end_c;
  logic [REC_W-1:0]  rec_inc_c;

  logic              busy_nx;
  logic              done_nx;
  logic              reset_trigger_nx;
  logic              reset_max_sum_nx;

  // abort outranks every other event in the same cycle
  assign start_c      = ((state == ST_IDLE) || (state == ST_DONE)) && arm && !abort;
  assign trig_hit_c   = (state == ST_ARMED) && trig_in && !abort;
  assign beat_valid_c = (state == ST_CAPTURE) && s_axis_tvalid && !abort;
  assign beat_last_c  = (LEN_W'(beat_cnt + LEN_W'(1)) == cfg.len);
  assign rec_end_c    = accept_c && beat_last_c;
  assign rec_inc_c    = REC_W'(records_done + REC_W'(1));
  assign run_end_c    = (cfg.max_rec != '0) && (rec_inc_c == cfg.max_rec);

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      reset_trigger <= 1'b0;
      reset_max_sum <= 1'b0;
    end else begin
      state         <= state_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      reset_trigger <= reset_trigger_nx;
      reset_max_sum <= reset_max_sum_nx;
    end
  end

  assign state_o = state;

  // Next-state decode
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm) state_nx = ST_CLEAR;
        ST_CLEAR:   if (phase_cnt == HOLD_W'(CLR_LAST)) state_nx = ST_ARMED;
        ST_ARMED:   if (trig_in) state_nx = ST_CAPTURE;
        ST_CAPTURE: if (rec_end_c) state_nx = run_end_c ? ST_DONE : ST_HOLDOFF;
        ST_HOLDOFF: if (phase_cnt == HOLD_W'(cfg.holdoff - HOLD_W'(1))) state_nx = ST_ARMED;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  // Output decode of the state being entered
  always_comb begin
    busy_nx          = 1'b0;
    done_nx          = 1'b0;
    reset_trigger_nx = 1'b0;
    reset_max_sum_nx = 1'b0;
    case (state_nx)
      ST_CLEAR: begin
        busy_nx          = 1'b1;
        reset_trigger_nx = 1'b1;
        reset_max_sum_nx = 1'b1;
      end
      ST_ARMED, ST_CAPTURE: busy_nx = 1'b1;
      ST_HOLDOFF: begin
        busy_nx          = 1'b1;
        reset_trigger_nx = 1'b1;
      end
      ST_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  // Run configuration, beat/phase counters and status
  always_ff @(posedge aclk) begin
    if (areset) begin
      cfg          <= '0;
      beat_cnt     <= '0;
      phase_cnt    <= '0;
      records_done <= '0;
      first_sample <= '0;
    end else begin
      if (start_c) begin
        cfg.len      <= at_least_one(record_len);
        cfg.max_rec  <= max_records;
        cfg.holdoff  <= at_least_one(holdoff_cycles);
        records_done <= '0;
      end
      if (trig_hit_c) begin
        first_sample <= cur_sample;
        beat_cnt     <= '0;
      end else if (accept_c) begin
        beat_cnt <= LEN_W'(beat_cnt + LEN_W'(1));
      end
      if (rec_end_c) begin
        records_done <= rec_inc_c;
      end
      if (state_nx != state) begin
        phase_cnt <= '0;
      end else if ((state == ST_CLEAR) || (state == ST_HOLDOFF)) begin
        phase_cnt <= HOLD_W'(phase_cnt + HOLD_W'(1));
      end
    end
  end

  capture_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .aclk          (aclk),
    .areset        (areset),
    .flush         (abort),
    .clr_drop      (start_c),
    .beat_valid    (beat_valid_c),
    .beat_data     (s_axis_tdata),
    .beat_last     (beat_last_c),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .accept_c      (accept_c),
    .dropped_count (dropped_count)
  );

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_capture_sequencer;

  localparam int unsigned DW  = 128;
  localparam int unsigned CLR = 4;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_ARMED = 2, M_CAPTURE = 3, M_HOLDOFF = 4, M_DONE = 5;

  logic          aclk = 1'b0;
  logic          areset, arm, abort, trig_in, s_axis_tvalid, m_axis_tready;
  logic [31:0]   record_len, holdoff_cycles;
  logic [15:0]   max_records;
  logic [63:0]   cur_sample;
  logic [DW-1:0] s_axis_tdata;

  logic          m_axis_tvalid, m_axis_tlast, reset_trigger, reset_max_sum, busy, done;
  logic [DW-1:0] m_axis_tdata;
  logic [2:0]    state_o;
  logic [15:0]   records_done;
  logic [63:0]   first_sample;
  logic [31:0]   dropped_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int            rm_cnt = 0, rt_cnt = 0, hs_cnt = 0, last_cnt = 0;
  logic [DW-1:0] last_data = '0;

  capture_sequencer #(.DATA_WIDTH(DW), .CLEAR_CYCLES(CLR)) dut (
    .aclk(aclk), .areset(areset), .arm(arm), .abort(abort),
    .record_len(record_len), .max_records(max_records), .holdoff_cycles(holdoff_cycles),
    .trig_in(trig_in), .cur_sample(cur_sample),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .reset_trigger(reset_trigger), .reset_max_sum(reset_max_sum),
    .state_o(state_o), .busy(busy), .done(done),
    .records_done(records_done), .first_sample(first_sample), .dropped_count(dropped_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: countdowns for phases, a single slot for the output register
  int              m_mode = M_IDLE;
  int unsigned     m_clear_left = 0, m_hold_left = 0;
  longint unsigned m_got = 0, m_len = 1, m_hold = 1;
  logic [15:0]     m_max = '0, m_recs = '0;
  logic [31:0]     m_drops = '0;
  logic [63:0]     m_first = '0;
  bit              m_ov = 1'b0, m_ol = 1'b0, took = 1'b0;
  logic [DW-1:0]   m_od = '0;

  always @(posedge aclk) begin
    if (areset) begin
      m_mode = M_IDLE; m_recs = '0; m_drops = '0; m_first = '0;
      m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
    end else if (abort) begin
      m_mode = M_IDLE; m_ov = 1'b0; m_ol = 1'b0;
    end else begin
      took = 1'b0;
      if (m_mode == M_CAPTURE && s_axis_tvalid) begin
        if (m_ov && !m_axis_tready) begin
          if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
        end else begin
          m_ov = 1'b1; m_od = s_axis_tdata; m_got = m_got + 1;
          m_ol = (m_got == m_len); took = 1'b1;
        end
      end
      if (!took && m_ov && m_axis_tready) m_ov = 1'b0;
      case (m_mode)
        M_IDLE, M_DONE: if (arm) begin
          m_mode = M_CLEAR; m_clear_left = CLR; m_recs = '0; m_drops = '0;
          m_len  = (record_len == 0) ? 1 : longint'(record_len);
          m_max  = max_records;
          m_hold = (holdoff_cycles == 0) ? 1 : longint'(holdoff_cycles);
        end
        M_CLEAR: begin
          m_clear_left = m_clear_left - 1;
          if (m_clear_left == 0) m_mode = M_ARMED;
        end
        M_ARMED: if (trig_in) begin
          m_first = cur_sample; m_got = 0; m_mode = M_CAPTURE;
        end
        M_CAPTURE: if (took && m_ol) begin
          m_recs = m_recs + 16'd1;
          m_mode = (m_max != 0 && m_recs == m_max) ? M_DONE : M_HOLDOFF;
          m_hold_left = 32'(m_hold);
        end
        M_HOLDOFF: begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0) m_mode = M_ARMED;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge aclk) begin
    if (chk_en) begin
      check("state_o", 128'(state_o), 128'(m_mode));
      check("busy", 128'(busy), 128'(m_mode >= M_CLEAR && m_mode <= M_HOLDOFF));
      check("done", 128'(done), 128'(m_mode == M_DONE));
      check("reset_trigger", 128'(reset_trigger), 128'(m_mode == M_CLEAR || m_mode == M_HOLDOFF));
      check("reset_max_sum", 128'(reset_max_sum), 128'(m_mode == M_CLEAR));
      check("records_done", 128'(records_done), 128'(m_recs));
      check("first_sample", 128'(first_sample), 128'(m_first));
      check("dropped_count", 128'(dropped_count), 128'(m_drops));
      check("m_axis_tvalid", 128'(m_axis_tvalid), 128'(m_ov));
      if (m_ov) begin
        check("m_axis_tdata", m_axis_tdata, m_od);
        check("m_axis_tlast", 128'(m_axis_tlast), 128'(m_ol));
      end
    end
  end

  always @(negedge aclk) begin
    if (reset_max_sum) rm_cnt++;
    if (reset_trigger) rt_cnt++;
  end

  always @(posedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      hs_cnt++;
      if (m_axis_tlast) begin
        last_cnt++;
        last_data = m_axis_tdata;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
  endtask

  task automatic start_capture(input logic [31:0] len, input logic [15:0] mx, input logic [31:0] hold);
    record_len = len; max_records = mx; holdoff_cycles = hold;
    pulse_arm(); tick(5);
    trig_in = 1'b1; tick(1); trig_in = 1'b0;
  endtask

  task automatic beat();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
    tick(1);
  endtask

  int b_rm, b_rt, b_hs, b_last;

  initial begin
    areset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    record_len = 32'd4; max_records = 16'd1; holdoff_cycles = 32'd1; cur_sample = '0;
    tick(3);
    check("rst state_o", 128'(state_o), 128'(0));
    check("rst m_axis_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst records_done", 128'(records_done), 128'(0));
    areset = 1'b0;
    chk_en = 1'b1;

    // Basic capture
    b_rm = rm_cnt; b_hs = hs_cnt; b_last = last_cnt;
    record_len = 32'd4; max_records = 16'd1;
    pulse_arm(); tick(7);
    check("basic clear cycles", 128'(rm_cnt - b_rm), 128'(4));
    check("basic armed", 128'(state_o), 128'(2));
    cur_sample = 64'd100; trig_in = 1'b1; tick(1); trig_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(i + 1); tick(1);
    end
    s_axis_tvalid = 1'b0; tick(3);
    check("basic beats", 128'(hs_cnt - b_hs), 128'(4));
    check("basic tlast count", 128'(last_cnt - b_last), 128'(1));
    check("basic tlast beat", last_data, 128'(4));
    check("basic first_sample", 128'(first_sample), 128'(100));
    check("basic done", 128'(done), 128'(1));
    check("basic records_done", 128'(records_done), 128'(1));

    // Multiple records with holdoff, trigger and stream held active
    b_rm = rm_cnt; b_rt = rt_cnt; b_hs = hs_cnt; b_last = last_cnt;
    record_len = 32'd2; max_records = 16'd3; holdoff_cycles = 32'd5;
    trig_in = 1'b1;
    pulse_arm();
    for (int i = 0; i < 40; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = DW'(1000 + i); tick(1);
    end
    s_axis_tvalid = 1'b0; trig_in = 1'b0; tick(2);
    check("multi tlast count", 128'(last_cnt - b_last), 128'(3));
    check("multi beats", 128'(hs_cnt - b_hs), 128'(6));
    check("multi records_done", 128'(records_done), 128'(3));
    check("multi done", 128'(done), 128'(1));
    check("multi reset_trigger cycles", 128'(rt_cnt - b_rt), 128'(4 + 5 + 5));
    check("multi reset_max_sum cycles", 128'(rm_cnt - b_rm), 128'(4));

    // Backpressure
    b_hs = hs_cnt; b_last = last_cnt;
    start_capture(32'd3, 16'd1, 32'd1);
    m_axis_tready = 1'b0;
    beat(); beat(); beat();
    s_axis_tvalid = 1'b0;
    check("bp dropped_count", 128'(dropped_count), 128'(2));
    check("bp held", 128'(m_axis_tvalid), 128'(1));
    check("bp records_done", 128'(records_done), 128'(0));
    m_axis_tready = 1'b1; tick(1);
    beat(); beat();
    s_axis_tvalid = 1'b0; tick(3);
    check("bp beats", 128'(hs_cnt - b_hs), 128'(3));
    check("bp tlast count", 128'(last_cnt - b_last), 128'(1));
    check("bp done", 128'(done), 128'(1));

    // Abort mid-record
    b_last = last_cnt;
    start_capture(32'd8, 16'd0, 32'd1);
    beat(); beat(); beat();
    s_axis_tvalid = 1'b0; abort = 1'b1; tick(1); abort = 1'b0;
    check("abort state_o", 128'(state_o), 128'(0));
    check("abort tvalid", 128'(m_axis_tvalid), 128'(0));
    check("abort records_done", 128'(records_done), 128'(0));
    tick(2);
    check("abort no tlast", 128'(last_cnt - b_last), 128'(0));

    // Abort and trigger together while armed
    record_len = 32'd2; max_records = 16'd1;
    pulse_arm(); tick(5);
    abort = 1'b1; trig_in = 1'b1; cur_sample = 64'd777; tick(1);
    abort = 1'b0; trig_in = 1'b0;
    check("abort+trig state_o", 128'(state_o), 128'(0));

    // arm during capture is ignored
    b_rm = rm_cnt;
    start_capture(32'd3, 16'd1, 32'd1);
    beat();
    arm = 1'b1; beat(); arm = 1'b0;
    beat();
    s_axis_tvalid = 1'b0; tick(3);
    check("arm in capture records_done", 128'(records_done), 128'(1));
    check("arm in capture state_o", 128'(state_o), 128'(5));
    check("arm in capture clears", 128'(rm_cnt - b_rm), 128'(4));

    // record_len = 0 gives single-beat records
    b_hs = hs_cnt; b_last = last_cnt;
    record_len = 32'd0; max_records = 16'd2; holdoff_cycles = 32'd1;
    trig_in = 1'b1;
    pulse_arm();
    for (int i = 0; i < 15; i++) beat();
    s_axis_tvalid = 1'b0; trig_in = 1'b0; tick(2);
    check("len0 tlast count", 128'(last_cnt - b_last), 128'(2));
    check("len0 beats", 128'(hs_cnt - b_hs), 128'(2));
    check("len0 records_done", 128'(records_done), 128'(2));

    // Reset with the output register full
    cur_sample = 64'h1234;
    start_capture(32'd8, 16'd0, 32'd1);
    m_axis_tready = 1'b0;
    beat(); beat();
    s_axis_tvalid = 1'b0;
    check("pre-reset full", 128'(m_axis_tvalid), 128'(1));
    areset = 1'b1; tick(1); areset = 1'b0;
    check("reset state_o", 128'(state_o), 128'(0));
    check("reset tvalid", 128'(m_axis_tvalid), 128'(0));
    check("reset tlast", 128'(m_axis_tlast), 128'(0));
    check("reset first_sample", 128'(first_sample), 128'(0));
    check("reset dropped_count", 128'(dropped_count), 128'(0));
    check("reset flags", 128'({reset_trigger, reset_max_sum, busy, done}), 128'(0));
    m_axis_tready = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      arm            = ($urandom_range(0, 19) == 0);
      abort          = ($urandom_range(0, 149) == 0);
      areset         = ($urandom_range(0, 599) == 0);
      trig_in        = ($urandom_range(0, 3) == 0);
      s_axis_tvalid  = ($urandom_range(0, 1) == 1);
      s_axis_tdata   = {$urandom, $urandom, $urandom, $urandom};
      m_axis_tready  = ($urandom_range(0, 3) != 0);
      cur_sample     = {$urandom, $urandom};
      record_len     = 32'($urandom_range(0, 5));
      max_records    = 16'($urandom_range(0, 3));
      holdoff_cycles = 32'($urandom_range(0, 4));
      tick(1);
    end
    arm = 1'b0; abort = 1'b0; areset = 1'b0; trig_in = 1'b0; s_axis_tvalid = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of the sample beat in the stream.
REQ-002 Parameter CLEAR_CYCLES, default 4, number of cycles the clear pulses are held after arm.
REQ-003 aclk  in  1  single clock; all logic is on the rising edge.
REQ-004 areset  in  1  reset; synchronous, active-high.
REQ-005 arm  in  1  single-cycle pulse that starts an acquisition run.
REQ-006 abort  in  1  single-cycle pulse that ends the run immediately.
REQ-007 record_len  in  32  beats per record; the value 0 is treated as 1.
REQ-008 max_records  in  16  records per run; the value 0 means unlimited.
REQ-009 holdoff_cycles  in  32  idle cycles between records.
REQ-010 trig_in  in  1  trigger-active flag from the ADC trigger datapath.
REQ-011 cur_sample  in  64  free-running sample counter from the ADC.
REQ-012 s_axis_tvalid / s_axis_tdata  in  1 / DATA_WIDTH  ADC beat stream; it has no tready.
REQ-013 m_axis_tvalid / m_axis_tdata / m_axis_tlast  out  1 / DATA_WIDTH / 1  record stream.
REQ-014 m_axis_tready  in  1  downstream ready.
REQ-015 reset_trigger / reset_max_sum  out  1 / 1  clear controls driven to the ADC.
REQ-016 state_o  out  3  current state encoding.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 done  out  1  high in DONE.
REQ-019 records_done  out  16  records completed in the current run.
REQ-020 first_sample  out  64  cur_sample latched at the start of the latest record.
REQ-021 dropped_count  out  32  beats lost to backpressure; saturating.

Function
REQ-022 States and encodings: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, HOLDOFF=4, DONE=5.
REQ-023 IDLE or DONE with arm=1 goes to CLEAR on the next cycle; it also zeroes records_done and dropped_count.
REQ-024 CLEAR holds reset_trigger=1 and reset_max_sum=1 for exactly CLEAR_CYCLES cycles, then goes to ARMED.
REQ-025 ARMED with trig_in=1 goes to CAPTURE; on the same edge it latches first_sample <= cur_sample and zeroes the beat counter.
REQ-026 In CAPTURE, each s_axis_tvalid=1 beat loads a 1-entry output register.
  - Latency from s_axis to m_axis is 1 cycle.
  - m_axis_tvalid stays high until the handshake tvalid&tready completes.
REQ-027 If a beat arrives while the output register is full and m_axis_tready=0:
  - the beat is discarded;
  - dropped_count increments, saturating at 0xFFFFFFFF;
  - the beat is not counted toward record_len.
REQ-028 If the register is full and m_axis_tready=1 when a beat arrives, the new beat replaces the drained one in the same cycle with no drop.
REQ-029 The beat that makes the accepted count equal record_len carries m_axis_tlast=1.
  - On that same edge, records_done increments.
  - State goes to DONE if records_done+1 == max_records (and max_records != 0); otherwise it goes to HOLDOFF.
REQ-030 On leaving CAPTURE, the last beat may still be pending in the output register; it is held until accepted.
REQ-031 HOLDOFF drives reset_trigger=1 for holdoff_cycles cycles (minimum 1), then goes to ARMED.
REQ-032 trig_in is ignored outside ARMED.
REQ-033 abort in any state goes to IDLE on the next edge.
  - The output register is flushed: m_axis_tvalid=0, and a partial record carries no tlast.
  - Counters keep their values.
REQ-034 abort has priority over arm, trig_in and the record end when they occur in the same cycle.
REQ-035 arm outside IDLE/DONE is ignored.
REQ-036 record_len, max_records and holdoff_cycles are sampled on entry to CLEAR; changes mid-run take effect on the next arm.
REQ-037 reset_max_sum is 0 in every state except CLEAR.
REQ-038 reset_trigger is 0 in every state except CLEAR and HOLDOFF.

Reset
REQ-039 While areset=1, on the clock edge:
  - state goes to IDLE;
  - all outputs and counters go to 0, including m_axis_tvalid, m_axis_tlast, reset_trigger, reset_max_sum, busy, done, records_done, first_sample and dropped_count;
  - the output register is emptied.
REQ-040 areset asserted mid-CAPTURE discards the pending beat, and no tlast is emitted.

Structure
REQ-041 The state encoding and the default widths (DATA_WIDTH, the counter widths) shall live in a shared package, adc_pkg.
REQ-042 The 1-entry output register with its drop counting shall be one sub-module, capture_out_reg; the state machine and counters stay in capture_sequencer.

Verification
REQ-043 Basic capture:
  - Stimulus: record_len=4, max_records=1, arm.
  - Required: reset_trigger and reset_max_sum high for 4 cycles.
  - Then with trig_in=1, cur_sample=100 and 4 beats at tready=1: 4 beats out with tlast on beat 4, first_sample=100, done=1, records_done=1.
REQ-044 Multiple records with holdoff:
  - Stimulus: record_len=2, max_records=3, holdoff_cycles=5, trig_in held high.
  - Required: 3 records each ending in tlast; reset_trigger high 5 cycles between records; DONE after the third record.
REQ-045 Backpressure:
  - Stimulus: record_len=3, tready=0 during 3 consecutive beats.
  - Required: 1 beat held, dropped_count=2, and the record completes only after 2 more accepted beats.
REQ-046 Abort mid-record:
  - Stimulus: record_len=8, abort after beat 3.
  - Required: IDLE next cycle, m_axis_tvalid=0, no tlast, records_done=0.
REQ-047 Simultaneous events:
  - Stimulus A: abort and trig_in in the same cycle in ARMED. Required: IDLE.
  - Stimulus B: arm during CAPTURE. Required: ignored.
  - Stimulus C: record_len=0. Required: single-beat records, each with tlast.
REQ-048 Reset:
  - Stimulus: areset pulsed mid-CAPTURE with the register full.
  - Required: all outputs 0 on the following cycle and state_o=0.
